// File: rtl/lane_striper.sv
// Stripes a word stream across the active subset of LANES physical lanes.
// Inserts SEP at frame ends and periodic clock-compensation bursts.
module lane_striper #(
  parameter int LANES     = 4,
  parameter int DATA_W    = 64,
  parameter int CC_PERIOD = 1024,
  parameter int CC_LEN    = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [LANES-1:0]               lane_mask,
  input  logic                           s_valid,
  input  logic                           s_last,
  input  logic [DATA_W-1:0]              s_data,
  output logic                           s_ready,
  output logic [LANES-1:0]               lane_ctrl,
  output logic [LANES-1:0][DATA_W-1:0]   lane_data,
  output logic [LANES-1:0]               active_mask
);

  localparam int CW = $clog2(LANES + 1);
  localparam int PW = (CC_PERIOD > 1) ? $clog2(CC_PERIOD) : 1;
  localparam int BW = $clog2(CC_LEN + 1);
  localparam logic [7:0] OS_IDLE = 8'h78;
  localparam logic [7:0] OS_CC   = 8'h55;
  localparam logic [7:0] OS_SEP  = 8'h1E;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  function automatic logic [CW-1:0] popcount(input logic [LANES-1:0] m);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) c = c + CW'(m[i]);
    return c;
  endfunction

  // Number of active lanes below lane idx, i.e. the stripe word index it carries.
  function automatic logic [CW-1:0] lane_rank(input logic [LANES-1:0] m, input int idx);
    logic [CW-1:0] c;
    c = '0;
    for (int j = 0; j < LANES; j++) begin
      if (j < idx) c = c + CW'(m[j]);
    end
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] word_at(input logic [LANES-1:0][DATA_W-1:0] b,
                                                input logic [CW-1:0] r);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int j = 0; j < LANES; j++) begin
      if (r == CW'(j)) w = b[j];
    end
    return w;
  endfunction

  state_t                          state_r, state_nxt_s;
  logic [LANES-1:0]                active_mask_r;
  logic [LANES-1:0][DATA_W-1:0]    buf_r;
  logic [CW-1:0]                   nwords_r;
  logic                            last_r;
  logic                            sep_pend_r;
  logic [PW-1:0]                   cnt_r;
  logic [BW-1:0]                   burst_left_r;
  logic [LANES-1:0]                lane_ctrl_r;
  logic [LANES-1:0][DATA_W-1:0]    lane_data_r;

  logic [CW-1:0]                   k_s;
  logic [CW-1:0]                   wr_idx_s;
  logic                            burst_s;
  logic                            s_ready_s;
  logic                            xfer_s;
  logic                            emit_s;
  logic [LANES-1:0]                ctrl_nxt_s;
  logic [LANES-1:0][DATA_W-1:0]    data_nxt_s;

  // Handshake, emission qualifier and next-state decode.
  always_comb begin
    k_s         = popcount(active_mask_r);
    burst_s     = (burst_left_r != '0);
    wr_idx_s    = (state_r == ST_IDLE) ? '0 : nwords_r;
    s_ready_s   = 1'b0;
    state_nxt_s = state_r;
    if (burst_s) begin
      s_ready_s = 1'b0;
    end else if (state_r == ST_IDLE) begin
      // A pending SEP still belongs to the previous frame; hold off the next one.
      s_ready_s = (active_mask_r != '0) && !sep_pend_r;
    end else if (state_r == ST_FILL) begin
      s_ready_s = 1'b1;
    end else begin
      s_ready_s = 1'b0;
    end
    xfer_s = s_valid && s_ready_s;
    emit_s = (state_r == ST_FULL) && !burst_s;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s) state_nxt_s = ((k_s == CW'(1)) || s_last) ? ST_FULL : ST_FILL;
        else        state_nxt_s = ST_IDLE;
      end
      ST_FILL: begin
        if (xfer_s && ((nwords_r + CW'(1) == k_s) || s_last)) state_nxt_s = ST_FULL;
        else                                                   state_nxt_s = ST_FILL;
      end
      ST_FULL: begin
        if (emit_s) state_nxt_s = last_r ? ST_IDLE : ST_FILL;
        else        state_nxt_s = ST_FULL;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next lane contents: CC burst beats stripe, stripe beats pending SEP.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      ctrl_nxt_s[i] = 1'b1;
      data_nxt_s[i] = DATA_W'(OS_IDLE);
    end
    if (burst_s) begin
      for (int i = 0; i < LANES; i++) data_nxt_s[i] = DATA_W'(OS_CC);
    end else if (state_r == ST_FULL) begin
      for (int i = 0; i < LANES; i++) begin
        if (active_mask_r[i] && (lane_rank(active_mask_r, i) < nwords_r)) begin
          ctrl_nxt_s[i] = 1'b0;
          data_nxt_s[i] = word_at(buf_r, lane_rank(active_mask_r, i));
        end else if (active_mask_r[i]) begin
          data_nxt_s[i] = DATA_W'(OS_SEP);
        end else begin
          data_nxt_s[i] = DATA_W'(OS_IDLE);
        end
      end
    end else if (sep_pend_r) begin
      for (int i = 0; i < LANES; i++)
        data_nxt_s[i] = active_mask_r[i] ? DATA_W'(OS_SEP) : DATA_W'(OS_IDLE);
    end else begin
      for (int i = 0; i < LANES; i++) data_nxt_s[i] = DATA_W'(OS_IDLE);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Stripe buffer, mask, SEP flag and clock-compensation timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_mask_r <= '0;
      buf_r         <= '0;
      nwords_r      <= '0;
      last_r        <= 1'b0;
      sep_pend_r    <= 1'b0;
      cnt_r         <= '0;
      burst_left_r  <= '0;
    end else begin
      if (cnt_r == PW'(CC_PERIOD - 1)) begin
        cnt_r        <= '0;
        burst_left_r <= BW'(CC_LEN);
      end else begin
        cnt_r <= cnt_r + PW'(1);
        if (burst_s) burst_left_r <= burst_left_r - BW'(1);
      end
      if ((state_r == ST_IDLE) && !sep_pend_r && !xfer_s) active_mask_r <= lane_mask;
      if (xfer_s) begin
        for (int i = 0; i < LANES; i++) begin
          if (wr_idx_s == CW'(i)) buf_r[i] <= s_data;
        end
        nwords_r <= wr_idx_s + CW'(1);
        last_r   <= s_last;
      end else if (emit_s) begin
        nwords_r <= '0;
      end
      if (emit_s && last_r && (nwords_r == k_s)) begin
        sep_pend_r <= 1'b1;
      end else if (!burst_s && (state_r != ST_FULL) && sep_pend_r) begin
        sep_pend_r <= 1'b0;
      end
    end
  end

  // Registered lane outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_ctrl_r <= '1;
      for (int i = 0; i < LANES; i++) lane_data_r[i] <= DATA_W'(OS_IDLE);
    end else begin
      lane_ctrl_r <= ctrl_nxt_s;
      lane_data_r <= data_nxt_s;
    end
  end

  assign s_ready     = s_ready_s;
  assign lane_ctrl   = lane_ctrl_r;
  assign lane_data   = lane_data_r;
  assign active_mask = active_mask_r;

endmodule

// File: tb/tb_lane_striper.sv
// Randomized and directed bench for lane_striper against a queue-based stripe model.
module tb_lane_striper;
  localparam int L  = 4;
  localparam int W  = 64;
  localparam int P  = 16;
  localparam int CL = 2;
  localparam logic [W-1:0] C_IDLE = 64'h78;
  localparam logic [W-1:0] C_CC   = 64'h55;
  localparam logic [W-1:0] C_SEP  = 64'h1E;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [L-1:0]         lane_mask = '0;
  logic                 s_valid = 1'b0;
  logic                 s_last = 1'b0;
  logic [W-1:0]         s_data = '0;
  logic                 s_ready;
  logic [L-1:0]         lane_ctrl;
  logic [L-1:0][W-1:0]  lane_data;
  logic [L-1:0]         active_mask;

  lane_striper #(.LANES(L), .DATA_W(W), .CC_PERIOD(P), .CC_LEN(CL)) dut (
    .clk(clk), .rst(rst), .lane_mask(lane_mask), .s_valid(s_valid), .s_last(s_last),
    .s_data(s_data), .s_ready(s_ready), .lane_ctrl(lane_ctrl), .lane_data(lane_data),
    .active_mask(active_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [L-1:0]        c;
    logic [L-1:0][W-1:0] d;
  } rec_t;

  rec_t         m_q[$];
  logic [W-1:0] m_words[$];
  logic [L-1:0] m_mask;
  bit           m_open;
  int           m_cnt;
  int           m_burst;
  rec_t         exp_out;
  rec_t         log_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;

  function automatic rec_t mk(input logic [L-1:0] c, input logic [W-1:0] d0,
                              input logic [W-1:0] d1, input logic [W-1:0] d2,
                              input logic [W-1:0] d3);
    rec_t r;
    r.c = c; r.d[0] = d0; r.d[1] = d1; r.d[2] = d2; r.d[3] = d3;
    return r;
  endfunction

  function automatic rec_t fill_rec(input logic [L-1:0] act, input logic [W-1:0] code);
    rec_t r;
    r.c = '1;
    for (int i = 0; i < L; i++) r.d[i] = act[i] ? code : C_IDLE;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [259:0] act, input logic [259:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_words.delete();
    m_mask  = '0;
    m_open  = 1'b0;
    m_cnt   = 0;
    m_burst = 0;
    exp_out = fill_rec('0, C_IDLE);
  endtask

  function automatic bit exp_ready();
    return (m_burst == 0) && (m_q.size() == 0) && (m_open || (m_mask != '0));
  endfunction

  // One clock edge of the behavioural stream: emission queue, word gathering, CC timer.
  task automatic model_step(input bit xfer);
    bit   burst;
    bit   qe;
    int   k;
    int   rk;
    rec_t r;
    burst = (m_burst > 0);
    qe    = (m_q.size() == 0);
    if (burst)    exp_out = fill_rec('1, C_CC);
    else if (!qe) exp_out = m_q.pop_front();
    else          exp_out = fill_rec('0, C_IDLE);
    if (!m_open && qe && !xfer) m_mask = lane_mask;
    if (xfer) begin
      m_words.push_back(s_data);
      m_open = 1'b1;
      k = $countones(m_mask);
      if ((m_words.size() == k) || s_last) begin
        rk = 0;
        for (int i = 0; i < L; i++) begin
          if (m_mask[i] && rk < m_words.size()) begin
            r.c[i] = 1'b0; r.d[i] = m_words[rk]; rk++;
          end else begin
            r.c[i] = 1'b1; r.d[i] = m_mask[i] ? C_SEP : C_IDLE;
          end
        end
        m_q.push_back(r);
        if (s_last && (m_words.size() == k)) m_q.push_back(fill_rec(m_mask, C_SEP));
        m_words.delete();
        m_open = !s_last;
      end
    end
    if (m_cnt == P - 1) begin
      m_cnt = 0; m_burst = CL;
    end else begin
      m_cnt++;
      if (burst) m_burst--;
    end
  endtask

  // Called at a negedge with inputs set; checks s_ready, advances one edge, checks outputs.
  task automatic tick(output bit acc);
    bit er;
    er = exp_ready();
    chk("s_ready", 260'(s_ready), 260'(er));
    acc = er && s_valid && !rst;
    @(posedge clk);
    if (rst) model_reset();
    else     model_step(acc);
    @(negedge clk);
    chk("lane_ctrl", 260'(lane_ctrl), 260'(exp_out.c));
    chk("lane_data", 260'(lane_data), 260'(exp_out.d));
    chk("active_mask", 260'(active_mask), 260'(m_mask));
    if (lane_ctrl != '1 || lane_data[0] == C_SEP || lane_data[1] == C_SEP ||
        lane_data[2] == C_SEP || lane_data[3] == C_SEP)
      log_q.push_back({lane_ctrl, lane_data});
  endtask

  task automatic push_word(input logic [W-1:0] d, input bit last);
    bit got;
    got = 1'b0;
    s_valid = 1'b1; s_data = d; s_last = last;
    for (int t = 0; t < 50 && !got; t++) tick(got);
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: word %0h not accepted within 50 cycles", d);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input logic [L-1:0] mask, input int n, input logic [W-1:0] base,
                            input int chg_at, input logic [L-1:0] chg_mask);
    bit a;
    lane_mask = mask;
    repeat (4) tick(a);
    log_q.delete();
    for (int w = 0; w < n; w++) begin
      if (w == chg_at) lane_mask = chg_mask;
      push_word(base + W'(w), w == n - 1);
    end
    repeat (12) tick(a);
  endtask

  task automatic chk_log(input string nm, input int idx, input rec_t e);
    if (idx < log_q.size()) chk(nm, 260'(log_q[idx]), 260'(e));
    else begin
      n_cmp++; n_bad++;
      $display("FAIL %s: log entry %0d missing (have %0d)", nm, idx, log_q.size());
    end
  endtask

  initial begin
    bit   a;
    logic [W-1:0] wd;
    int   first_cc;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ctrl", 260'(lane_ctrl), 260'(4'hF));
    chk("rst_data", 260'(lane_data), 260'({4{C_IDLE}}));
    chk("rst_ready", 260'(s_ready), 260'(1'b0));
    chk("rst_mask", 260'(active_mask), 260'(4'h0));
    rst = 1'b0;

    // Full-width frame of eight words ending on a full stripe.
    send_frame(4'b1111, 8, 64'hD0, 99, '0);
    chk("r34_n", 260'(log_q.size()), 260'(3));
    chk_log("r34_s0", 0, mk(4'b0000, 64'hD0, 64'hD1, 64'hD2, 64'hD3));
    chk_log("r34_s1", 1, mk(4'b0000, 64'hD4, 64'hD5, 64'hD6, 64'hD7));
    chk_log("r34_sep", 2, mk(4'b1111, C_SEP, C_SEP, C_SEP, C_SEP));

    // Single lane: every word is its own stripe.
    send_frame(4'b0100, 3, 64'hA0, 99, '0);
    chk("r35_n", 260'(log_q.size()), 260'(4));
    chk_log("r35_w0", 0, mk(4'b1011, C_IDLE, C_IDLE, 64'hA0, C_IDLE));
    chk_log("r35_w1", 1, mk(4'b1011, C_IDLE, C_IDLE, 64'hA1, C_IDLE));
    chk_log("r35_w2", 2, mk(4'b1011, C_IDLE, C_IDLE, 64'hA2, C_IDLE));
    chk_log("r35_sep", 3, mk(4'b1111, C_IDLE, C_IDLE, C_SEP, C_IDLE));

    // Sparse mask with a short final stripe.
    send_frame(4'b1011, 5, 64'hB0, 99, '0);
    chk("r36_n", 260'(log_q.size()), 260'(2));
    chk_log("r36_s0", 0, mk(4'b0100, 64'hB0, 64'hB1, C_IDLE, 64'hB2));
    chk_log("r36_s1", 1, mk(4'b1100, 64'hB3, 64'hB4, C_IDLE, C_SEP));

    // Mask change mid-frame only takes effect for the next frame.
    send_frame(4'b1111, 6, 64'hC0, 2, 4'b0011);
    chk_log("r38_s0", 0, mk(4'b0000, 64'hC0, 64'hC1, 64'hC2, 64'hC3));
    chk_log("r38_s1", 1, mk(4'b1100, 64'hC4, 64'hC5, C_SEP, C_SEP));
    chk("r38_mask", 260'(active_mask), 260'(4'b0011));
    send_frame(4'b0011, 2, 64'hE0, 99, '0);
    chk_log("r38_n0", 0, mk(4'b1100, 64'hE0, 64'hE1, C_IDLE, C_IDLE));
    chk_log("r38_n1", 1, mk(4'b1111, C_SEP, C_SEP, C_IDLE, C_IDLE));

    // Stripe completing on the counter-wrap edge waits out the CC burst.
    lane_mask = 4'b0001;
    for (int t = 0; t < 40 && !(m_cnt == P - 1 && exp_ready()); t++) tick(a);
    s_valid = 1'b1; s_last = 1'b1; s_data = 64'hF00D;
    tick(a);
    chk("r37_acc", 260'(a), 260'(1'b1));
    s_valid = 1'b0; s_last = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick(a);
      wd = (t < 2) ? C_CC : (t == 2) ? 64'hF00D : C_SEP;
      chk("r37_lane0", 260'(lane_data[0]), 260'(wd));
      if (t < 2) chk("r37_ready", 260'(s_ready), 260'(1'b0));
    end

    // Reset during FILL discards the partial stripe and restarts the CC timer.
    lane_mask = 4'b1111;
    repeat (4) tick(a);
    push_word(64'h11, 1'b0);
    push_word(64'h22, 1'b0);
    rst = 1'b1;
    #1;
    chk("r39_ctrl", 260'(lane_ctrl), 260'(4'hF));
    chk("r39_data", 260'(lane_data), 260'({4{C_IDLE}}));
    chk("r39_ready", 260'(s_ready), 260'(1'b0));
    chk("r39_mask", 260'(active_mask), 260'(4'h0));
    model_reset();
    @(negedge clk);
    tick(a);
    rst = 1'b0;
    log_q.delete();
    first_cc = 0;
    for (int t = 1; t <= 20; t++) begin
      tick(a);
      if (first_cc == 0 && lane_data[0] == C_CC) first_cc = t;
    end
    chk("r39_nolog", 260'(log_q.size()), 260'(0));
    chk("r39_cc_at", 260'(first_cc), 260'(17));

    // Randomized traffic with mask changes, idle gaps and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) lane_mask = L'($urandom_range(0, 15));
      s_valid = ($urandom_range(0, 3) != 0);
      s_last  = ($urandom_range(0, 4) == 0);
      s_data  = {$urandom, $urandom};
      if ($urandom_range(0, 699) == 0) begin
        rst = 1'b1;
        model_reset();
        tick(a);
        rst = 1'b0;
      end else begin
        tick(a);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lane_striper.md
LANE_STRIPER -- requirements
Module: lane_striper

Interface
REQ-001 SHALL have parameter LANES, default 4, number of physical lanes (1..8).
REQ-002 SHALL have parameter DATA_W, default 64, word width per lane (>=16).
REQ-003 SHALL have parameter CC_PERIOD, default 1024, cycles between clock-compensation bursts (>=8).
REQ-004 SHALL have parameter CC_LEN, default 3, cycles per clock-compensation burst (1..CC_PERIOD/2).
REQ-005 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port lane_mask  in  LANES  requested active lanes; bit i = lane i.
REQ-008 SHALL have port s_valid  in  1  input word valid.
REQ-009 SHALL have port s_last  in  1  word is last of frame; qualified by s_valid.
REQ-010 SHALL have port s_data  in  DATA_W  input word.
REQ-011 SHALL have port s_ready  out  1  block accepts word this cycle.
REQ-012 SHALL have port lane_ctrl  out  LANES  1 = lane carries ordered set, 0 = data word.
REQ-013 SHALL have port lane_data  out  LANES x DATA_W  per-lane word, registered.
REQ-014 SHALL have port active_mask  out  LANES  mask currently in use.

Function
REQ-015 Ordered-set codes in lane_data[7:0] with lane_ctrl=1, upper bits zero: IDLE=8'h78, CC=8'h55, SEP=8'h1E.
REQ-016 Transfer occurs on edge where s_valid && s_ready; K = popcount(active_mask).
REQ-017 States: IDLE (no frame open, buffer empty), FILL (gathering stripe), FULL (stripe complete, awaiting emission).
REQ-018 IDLE: active_mask loaded from lane_mask every cycle; mask never changes in FILL/FULL.
REQ-019 active_mask == 0: s_ready SHALL be 0; state stays IDLE.
REQ-020 Word n (0-based) of a stripe SHALL map to the n-th set bit of active_mask, ascending lane index.
REQ-021 IDLE->FILL on transfer with K>1 and !s_last; IDLE->FULL on transfer with K==1 or s_last.
REQ-022 FILL->FULL on transfer that is word K-1 of stripe or carries s_last.
REQ-023 s_ready SHALL be 1 in IDLE (mask nonzero) and FILL, 0 in FULL and during CC burst.
REQ-024 FULL: stripe emitted on outputs for exactly one cycle at next edge when no CC burst owns that edge; then ->FILL if frame still open, else ->IDLE.
REQ-025 Latency: completing transfer at edge E -> stripe on lane outputs from E+1 to E+2 when no CC; throughput K words per K+1 cycles.
REQ-026 Short stripe (s_last before K words): remaining active lanes SHALL carry SEP in the emission cycle; if s_last completes a full stripe, SEP is emitted on all active lanes the cycle after the stripe.
REQ-027 Non-emission cycles: active lanes carry IDLE; inactive lanes always lane_ctrl=1, IDLE.
REQ-028 Free-running counter 0..CC_PERIOD-1; on wrap, CC burst of CC_LEN cycles: all LANES carry CC, s_ready=0.
REQ-029 CC burst has priority over stripe and SEP emission; pending stripe/SEP held intact and emitted first cycle after burst.
REQ-030 s_valid low in FILL: state and partial stripe held, no timeout.
REQ-031 s_data/s_last SHALL be ignored when s_valid=0 or s_ready=0.

Reset
REQ-032 While rst=1: state IDLE, active_mask=0, s_ready=0, CC counter=0, no burst/stripe/SEP pending, all lane_ctrl=1, all lane_data=IDLE.
REQ-033 Reset mid-frame SHALL discard partial stripe; first post-reset edge loads lane_mask.

Verification (LANES=4, DATA_W=64, CC_PERIOD=16, CC_LEN=2)
REQ-034 mask=4'b1111, 8 words D0..D7, s_last on D7 -> lanes0..3 = D0..D3 then D4..D7, next emission cycle SEP on all, s_ready low each FULL cycle.
REQ-035 mask=4'b0100 (single lane 2), 3 words, last on 3rd -> each word on lane 2 only one cycle after acceptance, then SEP on lane 2; lanes 0,1,3 IDLE throughout.
REQ-036 mask=4'b1011, 5 words, last on 5th -> stripe1 lanes0,1,3=D0,D1,D2; stripe2 lanes0,1=D3,D4, lane3=SEP; lane2 IDLE.
REQ-037 Stripe completes on edge where counter wraps -> 2 cycles CC on all lanes, s_ready=0, stripe emitted intact cycle after burst.
REQ-038 lane_mask changed 4'b1111->4'b0011 mid-frame -> active_mask unchanged until frame ends and IDLE reached; next frame uses lanes 0,1.
REQ-039 rst pulsed during FILL with 2 of 4 words held -> outputs IDLE immediately, no partial stripe ever emitted, counter restarts at 0.
